pixel_config_seq: RTL and testbench

- Sequencer that drives the pixel-matrix configuration shift chain: it fetches 6-bit config words over a valid/ready stream and serialises them into the double-column tail registers, 32 words (192 bits) per row.
- After each row it asserts a push window, and it repeats for 128 rows.
- Its outputs connect directly to config_data, config_en, config_clk and push_en of the pixel configuration block. The downstream block shifts on the falling edge of config_clk while config_en is high.

---
 rtl/pixel_config_seq.sv | 205 ++++++++++++++++++++
 tb/tb_pixel_config_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_config_seq.sv
// Pixel-matrix configuration sequencer.
// Pulls 6-bit config words over a valid/ready stream and serialises them into the
// double-column tail registers: each word is presented on config_data with config_en
// high while one config_clk period is generated (downstream shifts on its falling edge).
// After WORDS_PER_ROW words a push_en window of PUSH_CYCLES cycles is issued; this
// repeats for ROWS rows, after which done pulses.
//
// Ports:
//   clk_40MHz   in   system clock, all state on rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse, starts a full configuration (ignored while busy)
//   abort       in   request to stop early; deferred until an in-flight shift completes
//   word_data   in   [5:0] next config word
//   word_valid  in   word_data valid
//   word_ready  out  word accepted when word_valid & word_ready on the same edge
//   config_data out  [5:0] word presented to the shift chain
//   config_en   out  shift enable to the chain
//   config_clk  out  registered, glitch-free shift clock
//   push_en     out  row push strobe
//   busy        out  sequence in progress
//   done        out  one-cycle pulse after the last row push
//   aborted     out  one-cycle pulse when an abort ends the sequence
//   row_idx     out  [6:0] current row
//   word_idx    out  [4:0] current word within the row
module pixel_config_seq #(
   parameter int unsigned WORDS_PER_ROW = 32,
   parameter int unsigned ROWS          = 128,
   parameter int unsigned HALF_PER      = 2,
   parameter int unsigned PUSH_CYCLES   = 4
) (
   input  logic       clk_40MHz,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [5:0] word_data,
   input  logic       word_valid,
   output logic       word_ready,
   output logic [5:0] config_data,
   output logic       config_en,
   output logic       config_clk,
   output logic       push_en,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic [6:0] row_idx,
   output logic [4:0] word_idx
);

   localparam logic [3:0] HalfLast = 4'(HALF_PER - 1);
   localparam logic [3:0] PushLast = 4'(PUSH_CYCLES - 1);
   localparam logic [4:0] WordLast = 5'(WORDS_PER_ROW - 1);
   localparam logic [6:0] RowLast  = 7'(ROWS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShiftHi,
      StShiftLo,
      StPush
   } state_e;

   state_e     state_q;
   logic [3:0] cnt_q;
   logic       abort_pend_q;
   logic       word_ready_q;
   logic [5:0] config_data_q;
   logic       config_en_q;
   logic       config_clk_q;
   logic       push_en_q;
   logic       busy_q;
   logic       done_q;
   logic       aborted_q;
   logic [6:0] row_q;
   logic [4:0] word_q;

   logic abort_eff;
   logic abort_exit;

   // An abort only terminates where no shift is in flight: in LOAD, in PUSH, or on the
   // last cycle of SHIFT_LO (after the falling edge has already been delivered).
   always_comb begin
      abort_eff  = abort | abort_pend_q;
      abort_exit = 1'b0;
      case (state_q)
         StLoad, StPush: abort_exit = abort_eff;
         StShiftLo:      abort_exit = abort_eff && (cnt_q == HalfLast);
         default:        abort_exit = 1'b0;
      endcase
   end

   always_ff @(posedge clk_40MHz) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         abort_pend_q  <= 1'b0;
         word_ready_q  <= 1'b0;
         config_data_q <= '0;
         config_en_q   <= 1'b0;
         config_clk_q  <= 1'b0;
         push_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
         row_q         <= '0;
         word_q        <= '0;
      end else if (abort_exit) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         abort_pend_q  <= 1'b0;
         word_ready_q  <= 1'b0;
         config_data_q <= '0;
         config_en_q   <= 1'b0;
         config_clk_q  <= 1'b0;
         push_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b1;
         row_q         <= '0;
         word_q        <= '0;
      end else begin
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         // Aborts seen in IDLE are dropped so they cannot kill the next run.
         abort_pend_q <= (state_q != StIdle) && abort_eff;
         case (state_q)
            StIdle: begin
               if (start && !abort) begin
                  state_q      <= StLoad;
                  cnt_q        <= '0;
                  row_q        <= '0;
                  word_q       <= '0;
                  word_ready_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            StLoad: begin
               if (word_valid) begin
                  state_q       <= StShiftHi;
                  cnt_q         <= '0;
                  config_data_q <= word_data;
                  config_en_q   <= 1'b1;
                  config_clk_q  <= 1'b1;
                  word_ready_q  <= 1'b0;
               end
            end
            StShiftHi: begin
               if (cnt_q == HalfLast) begin
                  state_q      <= StShiftLo;
                  cnt_q        <= '0;
                  config_clk_q <= 1'b0;  // downstream shift edge
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StShiftLo: begin
               if (cnt_q == HalfLast) begin
                  cnt_q <= '0;
                  if (word_q == WordLast) begin
                     state_q     <= StPush;
                     config_en_q <= 1'b0;
                     push_en_q   <= 1'b1;
                  end else begin
                     state_q      <= StLoad;
                     word_q       <= word_q + 5'd1;
                     word_ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StPush: begin
               if (cnt_q == PushLast) begin
                  cnt_q     <= '0;
                  push_en_q <= 1'b0;
                  if (row_q == RowLast) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q      <= StLoad;
                     row_q        <= row_q + 7'd1;
                     word_q       <= '0;
                     word_ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign word_ready  = word_ready_q;
   assign config_data = config_data_q;
   assign config_en   = config_en_q;
   assign config_clk  = config_clk_q;
   assign push_en     = push_en_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign aborted     = aborted_q;
   assign row_idx     = row_q;
   assign word_idx    = word_q;

endmodule

// File: tb/tb_pixel_config_seq.sv
// Directed bench for pixel_config_seq: a small instance (4 words/row, 2 rows,
// HALF_PER=2, PUSH_CYCLES=3) for the functional scenarios and a default-parameter
// instance for the full-length run.
module tb_pixel_config_seq;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Small instance
   logic       rst, start, abort, word_valid;
   logic [5:0] word_data;
   logic       word_ready, config_en, config_clk, push_en, busy, done, aborted;
   logic [5:0] config_data;
   logic [6:0] row_idx;
   logic [4:0] word_idx;

   // Default-parameter instance
   logic       d_rst, d_start, d_abort, d_valid;
   logic [5:0] d_data;
   logic       d_ready, d_en, d_cclk, d_push, d_busy, d_done, d_aborted;
   logic [5:0] d_cdata;
   logic [6:0] d_row;
   logic [4:0] d_word;

   pixel_config_seq #(
      .WORDS_PER_ROW(4),
      .ROWS         (2),
      .HALF_PER     (2),
      .PUSH_CYCLES  (3)
   ) dut (
      .clk_40MHz  (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .config_data(config_data),
      .config_en  (config_en),
      .config_clk (config_clk),
      .push_en    (push_en),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .row_idx    (row_idx),
      .word_idx   (word_idx)
   );

   pixel_config_seq dutd (
      .clk_40MHz  (clk),
      .rst        (d_rst),
      .start      (d_start),
      .abort      (d_abort),
      .word_data  (d_data),
      .word_valid (d_valid),
      .word_ready (d_ready),
      .config_data(d_cdata),
      .config_en  (d_en),
      .config_clk (d_cclk),
      .push_en    (d_push),
      .busy       (d_busy),
      .done       (d_done),
      .aborted    (d_aborted),
      .row_idx    (d_row),
      .word_idx   (d_word)
   );

   // Mid-cycle observers of the shift chain interface.
   logic       prev_cclk = 1'b0, prev_push = 1'b0;
   int         n_falls = 0, n_bad = 0, cur_len = 0;
   logic [5:0] fall_q[$];
   int         push_at_q[$];
   int         push_len_q[$];

   always @(negedge clk) begin
      prev_cclk <= config_clk;
      prev_push <= push_en;
      if (prev_cclk === 1'b1 && config_clk === 1'b0) begin
         fall_q.push_back(config_data);
         n_falls <= n_falls + 1;
         if (config_en !== 1'b1) n_bad <= n_bad + 1;
      end
      if (prev_push !== 1'b1 && push_en === 1'b1) push_at_q.push_back(n_falls);
      if (push_en === 1'b1) cur_len <= (prev_push === 1'b1) ? cur_len + 1 : 1;
      if (prev_push === 1'b1 && push_en !== 1'b1) push_len_q.push_back(cur_len);
   end

   logic d_prev_cclk = 1'b0, d_prev_push = 1'b0;
   int   d_falls = 0, d_bad = 0, d_pushes = 0;

   always @(negedge clk) begin
      d_prev_cclk <= d_cclk;
      d_prev_push <= d_push;
      if (d_prev_cclk === 1'b1 && d_cclk === 1'b0) begin
         d_falls <= d_falls + 1;
         if (d_en !== 1'b1) d_bad <= d_bad + 1;
      end
      if (d_prev_push !== 1'b1 && d_push === 1'b1) d_pushes <= d_pushes + 1;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One configuration on the small instance with continuous valid and words 1,2,3...
   // Optional: stall before word index stall_at, abort in SHIFT_HI of word 2,
   // start pulse mid-run, reset while config_clk=1 in row 1.
   task automatic run_cfg(input string tag, input int stall_at, input int stall_len,
                          input bit do_abort, input bit mid_start, input bit do_rst,
                          output int end_cyc);
      int cyc, nxt, stall_n;
      bit stalling, abort_sent, hs;
      cyc = 0; nxt = 0; stall_n = 0; stalling = 0; abort_sent = 0;
      end_cyc = -1;
      word_valid = 1'b1;
      word_data  = 6'd1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_acc_busy"}, busy, 1);
      chk({tag, "_acc_ready"}, word_ready, 1);
      chk({tag, "_acc_row"}, row_idx, 0);
      chk({tag, "_acc_word"}, word_idx, 0);
      for (int k = 0; k < 400; k++) begin
         abort = 1'b0;
         if (do_rst && row_idx == 7'd1 && config_clk == 1'b1) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            end_cyc = cyc + 1;
            chk({tag, "_ready"}, word_ready, 0);
            chk({tag, "_cdata"}, config_data, 0);
            chk({tag, "_en"}, config_en, 0);
            chk({tag, "_cclk"}, config_clk, 0);
            chk({tag, "_push"}, push_en, 0);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_done"}, done, 0);
            chk({tag, "_aborted"}, aborted, 0);
            chk({tag, "_row"}, row_idx, 0);
            chk({tag, "_word"}, word_idx, 0);
            tick();
            tick();
            chk({tag, "_idle_busy"}, busy, 0);
            chk({tag, "_idle_ready"}, word_ready, 0);
            return;
         end
         if (!stalling && stall_n == 0 && stall_len > 0 && nxt == stall_at && word_ready)
            stalling = 1;
         if (stalling) begin
            chk({tag, "_stall_ready"}, word_ready, 1);
            chk({tag, "_stall_cclk"}, config_clk, 0);
            word_valid = 1'b0;
            stall_n++;
            if (stall_n == stall_len) stalling = 0;
         end else begin
            word_valid = 1'b1;
         end
         if (do_abort && !abort_sent && nxt == 2 && config_clk == 1'b1) begin
            abort = 1'b1;
            abort_sent = 1;
         end
         if (mid_start && cyc == 25) start = 1'b1;
         hs = word_ready && word_valid;
         tick();
         cyc++;
         start = 1'b0;
         if (hs) begin
            nxt++;
            word_data = 6'(nxt + 1);
         end
         if (mid_start && cyc == 26) begin
            chk({tag, "_midstart_row"}, row_idx, 1);
            chk({tag, "_midstart_word"}, word_idx, 0);
            chk({tag, "_midstart_busy"}, busy, 1);
         end
         if (done === 1'b1 || aborted === 1'b1) begin
            end_cyc = cyc;
            break;
         end
      end
      abort = 1'b0;
      word_valid = 1'b0;
   endtask

   // Full two-row run: done timing, busy fall, data order, push windows.
   task automatic check_full(input string tag, input int fb, input int pb, input int lb,
                             input int bb, input int exp_end, input int ec);
      chk({tag, "_end_cycle"}, ec, exp_end);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_fall"}, busy, 0);
      tick();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_nfalls"}, fall_q.size() - fb, 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_data%0d", tag, i), fall_q[fb + i], i + 1);
      chk({tag, "_npush"}, push_at_q.size() - pb, 2);
      chk({tag, "_push0_after"}, push_at_q[pb] - fb, 4);
      chk({tag, "_push1_after"}, push_at_q[pb + 1] - fb, 8);
      chk({tag, "_push0_len"}, push_len_q[lb], 3);
      chk({tag, "_push1_len"}, push_len_q[lb + 1], 3);
      chk({tag, "_bad_edges"}, n_bad - bb, 0);
   endtask

   initial begin
      int ec, fb, pb, lb, bb, cyc, f0, p0, b0;

      rst = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
      d_rst = 1'b1; d_start = 1'b0; d_abort = 1'b0; d_valid = 1'b0; d_data = '0;
      tick();
      tick();
      chk("rst_ready", word_ready, 0);
      chk("rst_cdata", config_data, 0);
      chk("rst_en", config_en, 0);
      chk("rst_cclk", config_clk, 0);
      chk("rst_push", push_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_row", row_idx, 0);
      chk("rst_word", word_idx, 0);
      chk("rst_d_busy", d_busy, 0);
      rst = 1'b0;
      d_rst = 1'b0;
      tick();

      // Continuous valid, plus a start pulse while busy that must be ignored.
      fb = fall_q.size(); pb = push_at_q.size(); lb = push_len_q.size(); bb = n_bad;
      run_cfg("norm", 0, 0, 0, 1, 0, ec);
      check_full("norm", fb, pb, lb, bb, 46, ec);
      tick();

      // 7-cycle stall before the 3rd word.
      fb = fall_q.size(); pb = push_at_q.size(); lb = push_len_q.size(); bb = n_bad;
      run_cfg("stall", 2, 7, 0, 0, 0, ec);
      check_full("stall", fb, pb, lb, bb, 53, ec);
      tick();

      // start and abort together in IDLE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", busy, 0);
      chk("sa_ready", word_ready, 0);
      tick();
      chk("sa_busy2", busy, 0);

      // Abort in SHIFT_HI of word 2, row 0.
      fb = fall_q.size(); bb = n_bad; b0 = 0;
      run_cfg("abort", 0, 0, 1, 0, 0, ec);
      chk("abort_cycle", ec, 10);
      chk("abort_pulse", aborted, 1);
      chk("abort_en", config_en, 0);
      chk("abort_cclk", config_clk, 0);
      chk("abort_push", push_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_nfalls", fall_q.size() - fb, 2);
      chk("abort_data0", fall_q[fb], 1);
      chk("abort_data1", fall_q[fb + 1], 2);
      chk("abort_bad_edges", n_bad - bb, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done === 1'b1) b0++;
      end
      chk("abort_pulse_end", aborted, 0);
      chk("abort_no_done", b0, 0);

      // Reset while config_clk=1 in row 1, then a fresh run.
      run_cfg("midrst", 0, 0, 0, 0, 1, ec);
      chk("midrst_hit", ec, 25);
      fb = fall_q.size(); pb = push_at_q.size(); lb = push_len_q.size(); bb = n_bad;
      run_cfg("restart", 0, 0, 0, 0, 0, ec);
      check_full("restart", fb, pb, lb, bb, 46, ec);

      // Full-size default configuration.
      f0 = d_falls; p0 = d_pushes; b0 = d_bad;
      d_valid = 1'b1;
      d_data  = 6'h2a;
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
      cyc = -1;
      for (int k = 1; k <= 21500; k++) begin
         tick();
         if (d_done === 1'b1) begin
            cyc = k;
            break;
         end
      end
      d_valid = 1'b0;
      chk("dflt_done_cycle", cyc, 20992);
      chk("dflt_busy_fall", d_busy, 0);
      tick();
      chk("dflt_falls", d_falls - f0, 4096);
      chk("dflt_pushes", d_pushes - p0, 128);
      chk("dflt_bad_edges", d_bad - b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
